instr_mem_loader: RTL and testbench

Instruction encoder and instruction-memory writer for the RISC-V core. Accepts decoded instruction descriptors (format, fields, sign-extended immediate) over a valid/ready handshake. Packs each into a 32-bit R/I/S/SB word (the exact inverse of the core's immediate extraction) and writes it to consecutive instruction-memory words. Used by the testbench/boot path to load programs before the core leaves reset.

---
 rtl/instr_mem_loader_pkg.sv | 30 +++
 rtl/instr_mem_loader_encoder.sv | 47 ++++
 rtl/instr_mem_loader.sv | 146 ++++++++++++++
 tb/tb_instr_mem_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction encoder and instruction-memory loader.
// Holds format codes, FSM states, the NOP word and the immediate range limits.
package instr_mem_loader_pkg;

  localparam logic [1:0] FMT_R  = 2'd0;
  localparam logic [1:0] FMT_I  = 2'd1;
  localparam logic [1:0] FMT_S  = 2'd2;
  localparam logic [1:0] FMT_SB = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // addi x0,x0,0 is written in place of any word whose immediate is out of range
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
  localparam logic signed [31:0] IMM13_MIN = -32'sd4096;
  localparam logic signed [31:0] IMM13_MAX = 32'sd4094;

  function automatic logic imm_in_range(input logic signed [31:0] imm,
                                        input logic signed [31:0] lo,
                                        input logic signed [31:0] hi);
    return (imm >= lo) && (imm <= hi);
  endfunction

endpackage

// File: rtl/instr_mem_loader_encoder.sv
// Combinational R/I/S/SB packer; the bit placement is the inverse of the
// core's immediate extraction. range_err_o flags an unencodable immediate.
module instr_encoder
  import instr_mem_loader_pkg::*;
(
  input  logic [1:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        range_err_o
);

  // Pack fields by format and check the immediate against that format's reach
  always_comb begin
    word_o      = NOP_WORD;
    range_err_o = 1'b0;
    case (fmt_i)
      FMT_R: begin
        word_o      = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        range_err_o = 1'b0;
      end
      FMT_I: begin
        word_o      = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        range_err_o = !imm_in_range($signed(imm_i), IMM12_MIN, IMM12_MAX);
      end
      FMT_S: begin
        word_o      = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        range_err_o = !imm_in_range($signed(imm_i), IMM12_MIN, IMM12_MAX);
      end
      FMT_SB: begin
        word_o      = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                       imm_i[4:1], imm_i[11], opcode_i};
        range_err_o = !imm_in_range($signed(imm_i), IMM13_MIN, IMM13_MAX) || imm_i[0];
      end
      default: begin
        word_o      = NOP_WORD;
        range_err_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Burst loader: accepts instruction descriptors, encodes them and writes them
// to consecutive instruction-memory words, capturing the first range fault.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        fmt_i,
  input  logic [6:0]        opcode_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [31:0]       imm_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] err_addr_o
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));

  state_e            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [CNT_W-1:0]  remaining_r;
  logic              ready_r;
  logic              busy_r;
  logic              done_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_data_r;
  logic              err_r;
  logic [ADDR_W-1:0] err_addr_r;

  logic [31:0]       enc_word_s;
  logic              enc_err_s;
  logic              accept_s;

  instr_encoder u_encoder (
    .fmt_i       (fmt_i),
    .opcode_i    (opcode_i),
    .rd_i        (rd_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .funct3_i    (funct3_i),
    .funct7_i    (funct7_i),
    .imm_i       (imm_i),
    .word_o      (enc_word_s),
    .range_err_o (enc_err_s)
  );

  assign accept_s = valid_i && ready_r && (state_r == ST_LOAD);

  // Burst FSM with counters, registered memory port and error capture.
  // After the last accept LOAD lingers one cycle (ready low) so done_o lands
  // the cycle after the final write strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      remaining_r <= {CNT_W{1'b0}};
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_data_r  <= 32'h0000_0000;
      err_r       <= 1'b0;
      err_addr_r  <= {ADDR_W{1'b0}};
    end else begin
      mem_we_r <= 1'b0;
      done_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            addr_r      <= base_addr_i & WORD_MASK;
            remaining_r <= count_i;
            err_r       <= 1'b0;
            err_addr_r  <= {ADDR_W{1'b0}};
            busy_r      <= 1'b1;
            if (count_i == CNT_W'(0)) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              ready_r <= 1'b0;
            end else begin
              state_r <= ST_LOAD;
              ready_r <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            mem_we_r    <= 1'b1;
            mem_addr_r  <= addr_r;
            mem_data_r  <= enc_err_s ? NOP_WORD : enc_word_s;
            addr_r      <= addr_r + ADDR_W'(4);
            remaining_r <= remaining_r - CNT_W'(1);
            if (remaining_r == CNT_W'(1)) begin
              ready_r <= 1'b0;
            end
            if (enc_err_s && !err_r) begin
              err_r      <= 1'b1;
              err_addr_r <= addr_r;
            end
          end else if (remaining_r == CNT_W'(0)) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            ready_r <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          ready_r <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o    = ready_r;
  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign mem_we_o   = mem_we_r;
  assign mem_addr_o = mem_addr_r;
  assign mem_data_o = mem_data_r;
  assign err_o      = err_r;
  assign err_addr_o = err_addr_r;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: stimulus pushes expected writes and
// done pulses, a negedge monitor pops and compares them as the DUT emits them.
module tb_instr_mem_loader;
  import instr_mem_loader_pkg::*;

  localparam int ADDR_W = 10;
  localparam int CNT_W  = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic              is_done;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_i, start_i, valid_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [CNT_W-1:0]  count_i;
  logic [1:0] fmt_i;
  logic [6:0] opcode_i, funct7_i;
  logic [4:0] rd_i, rs1_i, rs2_i;
  logic [2:0] funct3_i;
  logic [31:0] imm_i;
  logic ready_o, mem_we_o, busy_o, done_o, err_o;
  logic [ADDR_W-1:0] mem_addr_o, err_addr_o;
  logic [31:0] mem_data_o;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_mem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .count_i(count_i), .valid_i(valid_i), .ready_o(ready_o), .fmt_i(fmt_i),
    .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_addr_o(err_addr_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every write strobe or done pulse must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_we_o) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h, none required", mem_addr_o, mem_data_o);
        end else begin
          e = sb.pop_front();
          if (e.is_done || e.addr !== mem_addr_o || e.data !== mem_data_o) begin
            errors++;
            $display("FAIL write: got addr 0x%03h data 0x%08h required %s addr 0x%03h data 0x%08h",
                     mem_addr_o, mem_data_o, e.is_done ? "done" : "write", e.addr, e.data);
          end
        end
      end
      if (done_o) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done_o=1, none required");
        end else begin
          e = sb.pop_front();
          if (!e.is_done) begin
            errors++;
            $display("FAIL done: got done_o=1 required write addr 0x%03h data 0x%08h", e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt);
    @(negedge clk);
    start_i = 1'b1; base_addr_i = base; count_i = cnt;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1; e.addr = '0; e.data = '0;
    sb.push_back(e);
  endtask

  task automatic send(input logic [1:0] f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input logic [ADDR_W-1:0] exp_addr, input logic [31:0] exp_data,
                      input int gap);
    exp_t e;
    int n;
    valid_i = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    fmt_i = f; opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
    funct3_i = f3; funct7_i = f7; imm_i = imm; valid_i = 1'b1;
    e.is_done = 1'b0; e.addr = exp_addr; e.data = exp_data;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready_o && n < 50);
    if (!ready_o) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got ready_o=0 for 50 cycles required 1");
      valid_i = 1'b0;
    end else begin
      @(posedge clk); #1;
      valid_i = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_o && n < 50);
    if (busy_o) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy_o=1 for 50 cycles required 0");
    end
    @(negedge clk);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; valid_i = 1'b0;
    base_addr_i = '0; count_i = '0; fmt_i = '0; opcode_i = '0;
    rd_i = '0; rs1_i = '0; rs2_i = '0; funct3_i = '0; funct7_i = '0; imm_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr_o}, 32'd0);
    chk("rst_mem_data", mem_data_o, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_err_addr", {22'd0, err_addr_o}, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd0);

    // Four-word burst covering every format
    do_start(10'h000, 8'd4);
    chk("burst_busy", {31'd0, busy_o}, 32'd1);
    send(FMT_R,  7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,        10'h000, 32'h002081B3, 0);
    send(FMT_I,  7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 10'h004, 32'hFFF00093, 0);
    send(FMT_S,  7'h23, 5'd0, 5'd0, 5'd2, 3'd2, 7'd0, 32'd4,        10'h008, 32'h00202223, 0);
    send(FMT_SB, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFF8, 10'h00C, 32'hFE000CE3, 0);
    push_done();
    wait_idle();
    chk("burst_err", {31'd0, err_o}, 32'd0);

    // Range errors: I imm 2048, SB odd offset
    do_start(10'h020, 8'd2);
    send(FMT_I,  7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 10'h020, NOP, 0);
    send(FMT_SB, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,    10'h024, NOP, 0);
    push_done();
    wait_idle();
    chk("range_err", {31'd0, err_o}, 32'd1);
    chk("range_err_addr", {22'd0, err_addr_o}, 32'h020);

    // Zero-length burst
    push_done();
    do_start(10'h040, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("zero_ready", {31'd0, ready_o}, 32'd0);
    end
    wait_idle();

    // Wrap at top of memory with valid gaps, boundary immediates
    do_start(10'h3FC, 8'd2);
    chk("wrap_err_cleared", {31'd0, err_o}, 32'd0);
    send(FMT_I,  7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 10'h3FC, 32'h80030293, 2);
    send(FMT_SB, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094,     10'h000, 32'h7E000FE3, 3);
    chk("wrap_ready_drop", {31'd0, ready_o}, 32'd0);
    push_done();
    fmt_i = FMT_R; opcode_i = 7'h33; valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wrap_third_ready", {31'd0, ready_o}, 32'd0);
    end
    valid_i = 1'b0;
    wait_idle();
    chk("wrap_err", {31'd0, err_o}, 32'd0);

    // Reset after one of three words, with the next descriptor pending
    do_start(10'h100, 8'd3);
    send(FMT_R, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 10'h100, 32'h002081B3, 0);
    fmt_i = FMT_I; opcode_i = 7'h13; imm_i = 32'd2048; valid_i = 1'b1; rst_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_we", {31'd0, mem_we_o}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("mid_rst_ready", {31'd0, ready_o}, 32'd0);
    chk("mid_rst_done", {31'd0, done_o}, 32'd0);
    chk("mid_rst_err", {31'd0, err_o}, 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0; valid_i = 1'b0;
    do_start(10'h200, 8'd1);
    send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 10'h200, 32'hFFF00093, 0);
    push_done();
    wait_idle();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
